seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal 4..64).
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 io_in_valid  input  1  request present on io_A/io_B/io_alu_op.
REQ-005 io_in_ready  output  1  block can accept a request this cycle.
REQ-006 io_A  input  WIDTH  operand A, unsigned.
REQ-007 io_B  input  WIDTH  operand B, unsigned.
REQ-008 io_alu_op  input  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 DIVU, 7 REMU.
REQ-009 io_out_valid  output  1  io_out holds a completed result.
REQ-010 io_out_ready  input  1  consumer accepts the result this cycle.
REQ-011 io_out  output  WIDTH  result.

Function
REQ-012 Three-state FSM: IDLE, BUSY, DONE; io_in_ready SHALL be 1 only in IDLE.
REQ-013 Accept = io_in_valid && io_in_ready; operands and opcode are latched on accept; later input changes have no effect.
REQ-014 ADD/SUB/AND/OR/XOR: IDLE->DONE on accept; io_out_valid asserted the next cycle (latency 1).
REQ-015 ADD/SUB result is modulo 2^WIDTH; carry/borrow discarded.
REQ-016 MUL: shift-add, one multiplier bit per cycle; IDLE->BUSY on accept, exactly WIDTH cycles in BUSY, then DONE; io_out_valid first high WIDTH+1 cycles after accept; result = low WIDTH bits of A*B.
REQ-017 Iteration counter of ceil(log2(WIDTH))+1 bits counts 0..WIDTH-1; BUSY->DONE when it reaches WIDTH-1.
REQ-018 DONE: io_out_valid=1, io_out held stable until io_out_valid && io_out_ready; then DONE->IDLE; no new request is accepted in that same cycle.
REQ-019 io_out_ready high before DONE SHALL have no effect.
REQ-020 io_out outside DONE SHALL retain its last value (0 after reset).

Reset
REQ-021 reset SHALL force IDLE, io_out_valid=0, io_in_ready=1 the following cycle, io_out=0, counter=0, and operand registers=0.
REQ-022 reset during BUSY or DONE SHALL abort the operation; no result is ever presented for it.
REQ-023 reset takes priority over any simultaneous accept or output handshake.

Configuration
REQ-024 Macro SEQ_ALU_DIV_EN: when defined, DIVU/REMU use restoring division, WIDTH cycles in BUSY, same timing as MUL.
REQ-025 With SEQ_ALU_DIV_EN, B==0: DIVU returns all ones, REMU returns A, still after WIDTH BUSY cycles.
REQ-026 Without SEQ_ALU_DIV_EN, opcodes 6/7 complete with latency 1 and io_out=0; no divider logic is instantiated.

Structure
REQ-027 Package seq_alu_pkg SHALL hold the opcode enumeration, the FSM state enumeration, and the default WIDTH constant.
REQ-028 Iterative datapath (shift-add multiplier, optional restoring divider, counter) SHALL be sub-module seq_alu_iter; opcode decode, FSM and handshake stay in seq_alu.

Verification
REQ-029 WIDTH=32, ADD A=0xFFFFFFFF B=1, out_ready=1 -> io_out=0x00000000, io_out_valid one cycle after accept, in_ready back high the cycle after.
REQ-030 MUL A=0x0001_0001 B=0x0001_0001 -> io_out=0x0002_0001 exactly 33 cycles after accept; in_ready=0 throughout.
REQ-031 SUB A=3 B=5 with out_ready=0 for 10 cycles -> io_out=0xFFFFFFFE held, out_valid=1 stable for all 10 cycles; one handshake; in_valid pulses during hold ignored.
REQ-032 MUL accepted, reset asserted on 5th BUSY cycle -> next cycle IDLE, out_valid=0, io_out=0; no result later.
REQ-033 SEQ_ALU_DIV_EN defined: DIVU 100/7 -> 14, REMU 100/7 -> 2, DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, each 33 cycles after accept; macro undefined: DIVU 100/7 -> 0 after 1 cycle.
REQ-034 WIDTH=8 back-to-back: XOR 0xF0^0x3C -> 0xCC, then MUL 15*17 -> 0xFF after 9 cycles; second request accepted only the cycle after the first output handshake.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcode/state enums and the default width for seq_alu (SEQ_ALU_DIV_EN enables the divider)
package seq_alu_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5,
        OP_DIVU = 3'd6,
        OP_REMU = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_iter(alu_op_e op);
`ifdef SEQ_ALU_DIV_EN
        return op inside {OP_MUL, OP_DIVU, OP_REMU};
`else
        return op == OP_MUL;
`endif
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/result handshake bundle between a requester (master) and seq_alu (slave)
interface seq_alu_if import seq_alu_pkg::*; #(parameter int WIDTH = WIDTH_DEF);

    logic             io_in_valid;
    logic             io_in_ready;
    logic [WIDTH-1:0] io_A;
    logic [WIDTH-1:0] io_B;
    alu_op_e          io_alu_op;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [WIDTH-1:0] io_out;

    modport master (
        output io_in_valid, io_A, io_B, io_alu_op, io_out_ready,
        input  io_in_ready, io_out_valid, io_out
    );

    modport slave (
        input  io_in_valid, io_A, io_B, io_alu_op, io_out_ready,
        output io_in_ready, io_out_valid, io_out
    );

endinterface

// File: rtl/seq_alu_iter.sv
// seq_alu_iter: one-bit-per-cycle shift-add multiplier and, with SEQ_ALU_DIV_EN, restoring divider
module seq_alu_iter import seq_alu_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             busy,
`ifdef SEQ_ALU_DIV_EN
    input  alu_op_e          op,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res
);

    localparam int CW = $clog2(WIDTH) + 1;

    // acc: product / partial remainder; sh: multiplier / dividend-quotient; mcand: multiplicand / divisor
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, sh, mcand;
    logic [WIDTH-1:0] acc_n, sh_n, mcand_n;
    logic             dv;

    assign last = busy && cnt == CW'(WIDTH - 1);

`ifdef SEQ_ALU_DIV_EN
    logic             div_q, rem_q, ge;
    logic [WIDTH:0]   rr;
    logic [WIDTH-1:0] diff;

    assign dv = op inside {OP_DIVU, OP_REMU};

    always_comb begin
        rr      = {acc, sh[WIDTH-1]};
        ge      = rr >= {1'b0, mcand};
        diff    = rr[WIDTH-1:0] - mcand;
        acc_n   = div_q ? (ge ? diff : rr[WIDTH-1:0]) : acc + (sh[0] ? mcand : '0);
        sh_n    = div_q ? {sh[WIDTH-2:0], ge} : sh >> 1;
        mcand_n = div_q ? mcand : mcand << 1;
        res     = div_q && !rem_q ? sh_n : acc_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q <= 1'b0;
            rem_q <= 1'b0;
        end else if (start) begin
            div_q <= dv;
            rem_q <= op == OP_REMU;
        end
    end
`else
    assign dv = 1'b0;

    always_comb begin
        acc_n   = acc + (sh[0] ? mcand : '0);
        sh_n    = sh >> 1;
        mcand_n = mcand << 1;
        res     = acc_n;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= '0;
            acc   <= '0;
            sh    <= '0;
            mcand <= '0;
        end else if (start) begin
            cnt   <= '0;
            acc   <= '0;
            sh    <= dv ? a : b;
            mcand <= dv ? b : a;
        end else if (busy) begin
            cnt   <= last ? '0 : cnt + 1'b1;
            acc   <= acc_n;
            sh    <= sh_n;
            mcand <= mcand_n;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked sequential ALU; SEQ_ALU_DIV_EN adds iterative DIVU/REMU, else they return 0
module seq_alu import seq_alu_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
    input logic      clock,
    input logic      reset,
    seq_alu_if.slave bus
);

    state_e           state;
    logic             accept, last;
    logic [WIDTH-1:0] quick, iter_res;

    assign accept = bus.io_in_valid && bus.io_in_ready;

    always_comb begin
        quick = bus.io_alu_op == OP_ADD ? bus.io_A + bus.io_B :
                bus.io_alu_op == OP_SUB ? bus.io_A - bus.io_B :
                bus.io_alu_op == OP_AND ? bus.io_A & bus.io_B :
                bus.io_alu_op == OP_OR  ? bus.io_A | bus.io_B :
                bus.io_alu_op == OP_XOR ? bus.io_A ^ bus.io_B : '0;
    end

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clock (clock),
        .reset (reset),
        .start (accept && is_iter(bus.io_alu_op)),
        .busy  (state == BUSY),
`ifdef SEQ_ALU_DIV_EN
        .op    (bus.io_alu_op),
`endif
        .a     (bus.io_A),
        .b     (bus.io_B),
        .last  (last),
        .res   (iter_res)
    );

    // io_in_ready is registered and only ever high in IDLE, so accept can only fire there
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            bus.io_in_ready  <= 1'b1;
            bus.io_out_valid <= 1'b0;
            bus.io_out       <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    bus.io_in_ready <= 1'b0;
                    if (is_iter(bus.io_alu_op)) state <= BUSY;
                    else begin
                        state            <= DONE;
                        bus.io_out_valid <= 1'b1;
                        bus.io_out       <= quick;
                    end
                end
                BUSY: if (last) begin
                    state            <= DONE;
                    bus.io_out_valid <= 1'b1;
                    bus.io_out       <= iter_res;
                end
                DONE: if (bus.io_out_ready) begin
                    state            <= IDLE;
                    bus.io_out_valid <= 1'b0;
                    bus.io_in_ready  <= 1'b1;
                end
                default: begin
                    state            <= IDLE;
                    bus.io_in_ready  <= 1'b1;
                    bus.io_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed checks of seq_alu at WIDTH=32 and WIDTH=8
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clock = ~clock;

    seq_alu_if #(.WIDTH(32)) i32 ();
    seq_alu_if #(.WIDTH(8))  i8 ();

    seq_alu #(.WIDTH(32)) dut32 (.clock(clock), .reset(reset), .bus(i32.slave));
    seq_alu #(.WIDTH(8))  dut8  (.clock(clock), .reset(reset), .bus(i8.slave));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic op32(input string tag, input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
        int   n;
        logic rdy_seen;
        @(negedge clock);
        check({tag, "_inrdy"}, i32.io_in_ready, 1);
        i32.io_out_ready = 1'b1;
        i32.io_in_valid  = 1'b1;
        i32.io_A         = a;
        i32.io_B         = b;
        i32.io_alu_op    = op;
        @(negedge clock);
        i32.io_in_valid = 1'b0;
        i32.io_A        = 32'h5A5A5A5A;
        i32.io_B        = 32'hA5A5A5A5;
        n = 1;
        rdy_seen = 1'b0;
        while (!i32.io_out_valid && n < 100) begin
            rdy_seen |= i32.io_in_ready;
            @(negedge clock);
            n++;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_out"}, i32.io_out, exp);
        check({tag, "_busyrdy"}, rdy_seen, 0);
        @(negedge clock);
        check({tag, "_back"}, {i32.io_in_ready, i32.io_out_valid}, 2'b10);
    endtask

    initial begin
        logic seen;
        i32.io_in_valid = 1'b0; i32.io_out_ready = 1'b0; i32.io_A = '0; i32.io_B = '0; i32.io_alu_op = OP_ADD;
        i8.io_in_valid  = 1'b0; i8.io_out_ready  = 1'b0; i8.io_A  = '0; i8.io_B  = '0; i8.io_alu_op  = OP_ADD;
        repeat (2) @(negedge clock);
        check("rst_rdy", i32.io_in_ready, 1);
        check("rst_val", i32.io_out_valid, 0);
        check("rst_out", i32.io_out, 0);
        reset = 1'b0;

        op32("add_wrap", OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 1);
        op32("sub_wrap", OP_SUB, 32'h0, 32'h1, 32'hFFFFFFFF, 1);
        op32("and", OP_AND, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1);
`ifdef SEQ_ALU_DIV_EN
        op32("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        op32("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        op32("divu_z", OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 33);
        op32("remu_z", OP_REMU, 32'd5, 32'd0, 32'd5, 33);
`else
        op32("divu_off", OP_DIVU, 32'd100, 32'd7, 32'd0, 1);
`endif
        op32("or", OP_OR, 32'hFF00FF00, 32'h0F0F0F0F, 32'hFF0FFF0F, 1);
        op32("xor", OP_XOR, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1);
        op32("mul", OP_MUL, 32'h00010001, 32'h00010001, 32'h00020001, 33);
        op32("mul_ones", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 33);
        op32("mul_ovf", OP_MUL, 32'h00010000, 32'h00010000, 32'h0, 33);

        // result held while the consumer stalls; requests during the hold are ignored
        @(negedge clock);
        i32.io_out_ready = 1'b0;
        i32.io_in_valid = 1'b1; i32.io_A = 32'd3; i32.io_B = 32'd5; i32.io_alu_op = OP_SUB;
        @(negedge clock);
        for (int k = 0; k < 10; k++) begin
            check("hold", {i32.io_out_valid, i32.io_in_ready, i32.io_out}, {2'b10, 32'hFFFFFFFE});
            i32.io_in_valid = k[0]; i32.io_A = 32'(k); i32.io_B = 32'd1; i32.io_alu_op = OP_ADD;
            @(negedge clock);
        end
        i32.io_in_valid = 1'b0;
        i32.io_out_ready = 1'b1;
        @(negedge clock);
        check("hold_hs", {i32.io_out_valid, i32.io_in_ready, i32.io_out}, {2'b01, 32'hFFFFFFFE});
        @(negedge clock);
        check("hold_once", i32.io_out_valid, 0);

        // reset on the 5th BUSY cycle of a MUL aborts it
        i32.io_in_valid = 1'b1; i32.io_A = 32'd7; i32.io_B = 32'd9; i32.io_alu_op = OP_MUL;
        @(negedge clock);
        i32.io_in_valid = 1'b0;
        repeat (4) @(negedge clock);
        check("abort_busy", i32.io_in_ready, 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_state", {i32.io_in_ready, i32.io_out_valid, i32.io_out}, {2'b10, 32'h0});
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            seen |= i32.io_out_valid;
        end
        check("abort_nores", seen, 0);

        // WIDTH=8 back-to-back: second request waits for the first handshake
        @(negedge clock);
        i8.io_out_ready = 1'b1;
        i8.io_in_valid = 1'b1; i8.io_A = 8'hF0; i8.io_B = 8'h3C; i8.io_alu_op = OP_XOR;
        @(negedge clock);
        i8.io_A = 8'd15; i8.io_B = 8'd17; i8.io_alu_op = OP_MUL;
        check("w8_xor", {i8.io_out_valid, i8.io_in_ready, i8.io_out}, {2'b10, 8'hCC});
        @(negedge clock);
        check("w8_gap", {i8.io_out_valid, i8.io_in_ready}, 2'b01);
        @(negedge clock);
        i8.io_in_valid = 1'b0;
        begin
            int n = 1;
            while (!i8.io_out_valid && n < 50) begin
                @(negedge clock);
                n++;
            end
            check("w8_mul_lat", n, 9);
        end
        check("w8_mul_out", i8.io_out, 8'hFF);
        @(negedge clock);
        check("w8_back", {i8.io_out_valid, i8.io_in_ready}, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
